pid: RTL and testbench

PID -- requirements
Module: pid

---
 rtl/pid_pkg.sv | 32 +++
 rtl/pid_mul.sv | 13 +
 rtl/pid.sv | 169 ++++++++++++++++
 tb/tb_pid.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and width helpers for the pid controller.
// All widths are derived from the BITS parameter of the instantiating module.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        PTERM,
        ITERM,
        DTERM,
        SUM
    } state_e;

    // Error e = sp - pv needs one extra bit for the sign.
    function automatic int err_w(input int bits);
        return bits + 1;
    endfunction

    function automatic int int_w(input int bits);
        return 2 * bits + 2;
    endfunction

    function automatic int sum_w(input int bits);
        return 2 * bits + 4;
    endfunction

    // Integrator magnitude limit: 2^(2*BITS) - 1.
    function automatic longint int_lim(input int bits);
        return (longint'(1) << (2 * bits)) - 1;
    endfunction

endpackage

// File: rtl/pid_mul.sv
// Combinational signed multiplier shared by the P, I and D steps.
module pid_mul #(
    parameter int AW = 6,
    parameter int BW = 5
) (
    input  logic signed [AW-1:0]    a_i,
    input  logic signed [BW-1:0]    b_i,
    output logic signed [AW+BW-1:0] p_o
);

    always_comb p_o = a_i * b_i;

endmodule

// File: rtl/pid.sv
// Sequential PID controller: one multiply per state, result clamped to BITS bits.
// Optional derivative term enabled by defining PID_DTERM_EN.
module pid
    import pid_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pv_stb,
    input  logic [BITS-1:0] sp,
    input  logic [BITS-1:0] pv,
    input  logic [BITS-1:0] kp,
    input  logic [BITS-1:0] ki,
    input  logic [BITS-1:0] kd,
    output logic [BITS-1:0] stimulus
);

    localparam int EW = err_w(BITS);
    localparam int DW = EW + 1;
    localparam int PW = DW + EW;
    localparam int IW = int_w(BITS);
    localparam int SW = sum_w(BITS);
    localparam logic signed [IW-1:0] ILIM = IW'(int_lim(BITS));
    localparam logic signed [IW:0]   ILIM_X = (IW+1)'(ILIM);
    localparam logic signed [SW-1:0] SMAX = SW'((1 << BITS) - 1);

    state_e state_q, state_d;

    logic [BITS-1:0] sp_q, pv_q, kp_q, ki_q;
    logic signed [EW-1:0] e_q, e_d;
    logic signed [PW-1:0] p_q, p_d;
    logic signed [IW-1:0] i_q, i_d;
    logic signed [IW:0]   i_sum;
    logic signed [SW-1:0] s_sum;
    logic [BITS-1:0]      stim_q, stim_d;

    logic signed [DW-1:0] mul_a;
    logic signed [EW-1:0] mul_b;
    logic signed [PW-1:0] mul_p;

`ifdef PID_DTERM_EN
    logic [BITS-1:0]      kd_q;
    logic signed [EW-1:0] eprev_q, eprev_d;
    logic signed [PW-1:0] d_q, d_d;
`else
    logic kd_unused;
    assign kd_unused = ^kd;
`endif

    pid_mul #(
        .AW(DW),
        .BW(EW)
    ) u_mul (
        .a_i(mul_a),
        .b_i(mul_b),
        .p_o(mul_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pv_stb) state_d = ERR;
            ERR:     state_d = PTERM;
            PTERM:   state_d = ITERM;
            ITERM:   state_d = DTERM;
            DTERM:   state_d = SUM;
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier operand select; gains are zero-extended so they stay non-negative.
    always_comb begin
        mul_a = DW'(e_q);
        mul_b = '0;
        case (state_q)
            PTERM: mul_b = {1'b0, kp_q};
            ITERM: mul_b = {1'b0, ki_q};
`ifdef PID_DTERM_EN
            DTERM: begin
                mul_a = DW'(e_q) - DW'(eprev_q);
                mul_b = {1'b0, kd_q};
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        e_d    = e_q;
        p_d    = p_q;
        i_d    = i_q;
        stim_d = stim_q;
`ifdef PID_DTERM_EN
        d_d     = d_q;
        eprev_d = eprev_q;
        s_sum   = SW'(p_q) + SW'(i_q) + SW'(d_q);
`else
        s_sum   = SW'(p_q) + SW'(i_q);
`endif
        i_sum = (IW+1)'(i_q) + (IW+1)'(mul_p);
        case (state_q)
            ERR:   e_d = $signed({1'b0, sp_q}) - $signed({1'b0, pv_q});
            PTERM: p_d = mul_p;
            ITERM: begin
                if (i_sum > ILIM_X)       i_d = ILIM;
                else if (i_sum < -ILIM_X) i_d = -ILIM;
                else                      i_d = IW'(i_sum);
            end
`ifdef PID_DTERM_EN
            DTERM: begin
                d_d     = mul_p;
                eprev_d = e_q;
            end
`endif
            SUM: begin
                if (s_sum < 0)         stim_d = '0;
                else if (s_sum > SMAX) stim_d = '1;
                else                   stim_d = s_sum[BITS-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q   <= '0;
            pv_q   <= '0;
            kp_q   <= '0;
            ki_q   <= '0;
            e_q    <= '0;
            p_q    <= '0;
            i_q    <= '0;
            stim_q <= '0;
`ifdef PID_DTERM_EN
            kd_q    <= '0;
            d_q     <= '0;
            eprev_q <= '0;
`endif
        end else begin
            if (state_q == IDLE && pv_stb) begin
                sp_q <= sp;
                pv_q <= pv;
                kp_q <= kp;
                ki_q <= ki;
`ifdef PID_DTERM_EN
                kd_q <= kd;
`endif
            end
            e_q    <= e_d;
            p_q    <= p_d;
            i_q    <= i_d;
            stim_q <= stim_d;
`ifdef PID_DTERM_EN
            d_q     <= d_d;
            eprev_q <= eprev_d;
`endif
        end
    end

    assign stimulus = stim_q;

endmodule

// File: tb/tb_pid.sv
module tb_pid;

  logic       clk;
  logic       reset;
  logic       pv_stb;
  logic [3:0] sp, pv, kp, ki, kd;
  logic [3:0] stimulus;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  val;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_fail;
  logic [3:0]  exp_stim;
  int unsigned samp;
  logic [3:0]  dexp1;

  pid #(.BITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .pv_stb  (pv_stb),
    .sp      (sp),
    .pv      (pv),
    .kp      (kp),
    .ki      (ki),
    .kd      (kd),
    .stimulus(stimulus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      n_cmp = n_cmp + 1;
      if (stimulus !== mon_e.val) begin
        n_fail = n_fail + 1;
        $display("FAIL stimulus cyc=%0d got=%0d expected=%0d", mon_e.cyc, stimulus, mon_e.val);
      end
    end
  end

  task automatic push(input int unsigned c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    exp_stim = 4'd0;
    push(cyc, 4'd0);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic [3:0] e, output int unsigned s);
    @(negedge clk);
    sp = a; pv = b; kp = c; ki = d; kd = e;
    pv_stb = 1'b1;
    s = cyc + 1;
  endtask

  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                     input logic [3:0] d, input logic [3:0] e, input logic [3:0] newv);
    int unsigned s;
    issue(a, b, c, d, e, s);
    for (int unsigned k = 1; k <= 4; k++) push(s + k, exp_stim);
    push(s + 5, newv);
    exp_stim = newv;
    @(negedge clk);
    pv_stb = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp = n_cmp + 1;
    if (stimulus !== newv) begin
      n_fail = n_fail + 1;
      $display("FAIL run stimulus cyc=%0d got=%0d expected=%0d", cyc, stimulus, newv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; pv_stb = 1'b0;
    sp = '0; pv = '0; kp = '0; ki = '0; kd = '0;
    exp_stim = 4'd0;
`ifdef PID_DTERM_EN
    dexp1 = 4'd4;
`else
    dexp1 = 4'd0;
`endif

    do_reset();
    run(4'd8, 4'd4, 4'd2, 4'd0, 4'd0, 4'd8);
    run(4'd8, 4'd4, 4'd2, 4'd0, 4'd0, 4'd8);

    do_reset();
    run(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, 4'd4);
    run(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, 4'd6);
    run(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, 4'd8);

    do_reset();
    run(4'd6, 4'd2, 4'd0, 4'd0, 4'd1, dexp1);
    run(4'd6, 4'd2, 4'd0, 4'd0, 4'd1, 4'd0);

    do_reset();
    run(4'd15, 4'd0, 4'd15, 4'd0, 4'd0, 4'd15);
    run(4'd2, 4'd10, 4'd1, 4'd0, 4'd0, 4'd0);

    do_reset();
    run(4'd0, 4'd15, 4'd0, 4'd15, 4'd0, 4'd0);
    run(4'd0, 4'd15, 4'd0, 4'd15, 4'd0, 4'd0);
    run(4'd15, 4'd0, 4'd15, 4'd3, 4'd0, 4'd15);

    do_reset();
    issue(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, samp);
    for (int unsigned k = 1; k <= 4; k++) push(samp + k, 4'd0);
    for (int unsigned k = 5; k <= 12; k++) push(samp + k, 4'd4);
    @(negedge clk);
    pv_stb = 1'b0;
    @(negedge clk);
    sp = 4'd15; pv = 4'd0; kp = 4'd15; ki = 4'd15; kd = 4'd0;
    pv_stb = 1'b1;
    @(negedge clk);
    pv_stb = 1'b0;
    repeat (10) @(negedge clk);
    exp_stim = 4'd4;
    run(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, 4'd6);

    do_reset();
    run(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, 4'd4);
    issue(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, samp);
    push(samp + 1, 4'd4);
    @(negedge clk);
    pv_stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_stim = 4'd0;
    push(cyc, 4'd0);
    #1;
    n_cmp = n_cmp + 1;
    if (stimulus !== 4'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL async reset stimulus cyc=%0d got=%0d expected=0", cyc, stimulus);
    end
    n_cmp = n_cmp + 1;
    if (dut.i_q !== '0) begin
      n_fail = n_fail + 1;
      $display("FAIL async reset integrator cyc=%0d got=%0d expected=0", cyc, dut.i_q);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    run(4'd5, 4'd3, 4'd1, 4'd1, 4'd0, 4'd4);

    for (int unsigned k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_cmp = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL stimulus cyc=%0d got=unchecked expected=%0d", mon_e.cyc, mon_e.val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    if (n_fail != 0) $display("TEST FAILED");
    else             $display("TEST PASSED");
    $finish;
  end

endmodule
